// File: rtl/pn_sequence_controller.sv
// Programmable PN flip-flop sequencer: a rewritable next-state table drives the
// P/N excitation of a WIDTH-bit bank stepped by start/stop/step commands.
module pn_sequence_controller #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_next,
  input  logic [WIDTH-1:0] term_state,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] n_out,
  output logic             busy,
  output logic             done,
  output logic             stuck,
  output logic             cfg_err,
  output logic [CNT_W-1:0] step_count
);
  localparam int DEPTH = 2 ** WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fsm_t;

  fsm_t             fsm_r;
  fsm_t             fsm_next_s;
  logic [WIDTH-1:0] tbl_r [DEPTH];
  logic [WIDTH-1:0] entry_s;
  logic [WIDTH-1:0] exc_p_s;
  logic [WIDTH-1:0] exc_n_s;
  logic [WIDTH-1:0] bank_next_s;
  logic             advance_s;
  logic             stuck_next_s;
  logic             cnt_clr_s;
  logic [CNT_W-1:0] cnt_next_s;

  assign entry_s = tbl_r[state];
  assign p_out   = entry_s & ~state;
  assign n_out   = entry_s & state;

  // Gated excitation into the bank: P=0, N=Q makes every PN flip-flop hold.
  always_comb begin
    if (advance_s) begin
      exc_p_s = p_out;
      exc_n_s = n_out;
    end else begin
      exc_p_s = {WIDTH{1'b0}};
      exc_n_s = state;
    end
    bank_next_s = (exc_n_s & state) | (exc_p_s & ~state);
  end

  // Command decode; RUN checks termination against entry_s, the post-advance state.
  always_comb begin
    advance_s    = 1'b0;
    fsm_next_s   = fsm_r;
    stuck_next_s = 1'b0;
    cnt_clr_s    = 1'b0;
    case (fsm_r)
      IDLE: begin
        if (start) begin
          fsm_next_s = RUN;
          cnt_clr_s  = 1'b1;
        end else begin
          advance_s = step;
        end
      end
      RUN: begin
        if (stop) begin
          fsm_next_s = IDLE;
        end else begin
          advance_s = 1'b1;
          if (entry_s == term_state) begin
            fsm_next_s = HALT;
          end else if (tbl_r[entry_s] == entry_s) begin
            fsm_next_s   = IDLE;
            stuck_next_s = 1'b1;
          end else begin
            fsm_next_s = RUN;
          end
        end
      end
      HALT: begin
        if (start) begin
          fsm_next_s = RUN;
          cnt_clr_s  = 1'b1;
        end else if (stop) begin
          fsm_next_s = IDLE;
        end else if (step) begin
          advance_s  = 1'b1;
          fsm_next_s = IDLE;
        end else begin
          fsm_next_s = HALT;
        end
      end
      default: begin
        fsm_next_s = IDLE;
      end
    endcase
  end

  // Saturating advance counter.
  always_comb begin
    if (cnt_clr_s) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (advance_s && (step_count != {CNT_W{1'b1}})) begin
      cnt_next_s = step_count + CNT_W'(1);
    end else begin
      cnt_next_s = step_count;
    end
  end

  // Falling-edge state; writes during RUN are dropped and flagged instead.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state      <= {WIDTH{1'b0}};
      fsm_r      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      stuck      <= 1'b0;
      cfg_err    <= 1'b0;
      step_count <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        tbl_r[i] <= WIDTH'(i + 1);
      end
    end else begin
      state      <= bank_next_s;
      fsm_r      <= fsm_next_s;
      busy       <= (fsm_next_s == RUN);
      done       <= (fsm_next_s == HALT);
      stuck      <= stuck_next_s;
      cfg_err    <= cfg_we && (fsm_r == RUN);
      step_count <= cnt_next_s;
      if (cfg_we && (fsm_r != RUN)) begin
        tbl_r[cfg_addr] <= cfg_next;
      end
    end
  end
endmodule

// File: tb/tb_pn_sequence_controller.sv
// Scoreboard bench for pn_sequence_controller: per-cycle expectations are queued
// as stimulus is driven and compared after the falling edge that consumes it.
module tb_pn_sequence_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we, start, stop, step;
  logic [1:0] cfg_addr, cfg_next, term_state;
  logic [1:0] state, p_out, n_out;
  logic       busy, done, stuck, cfg_err;
  logic [7:0] step_count;

  logic       s_cfg_we, s_start, s_stop, s_step;
  logic [1:0] s_cfg_addr, s_cfg_next, s_term_state;
  logic [1:0] s_state, s_p_out, s_n_out;
  logic       s_busy, s_done, s_stuck, s_cfg_err;
  logic [1:0] s_step_count;

  always #5 clk = ~clk;

  pn_sequence_controller #(.WIDTH(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_next(cfg_next),
    .term_state(term_state), .start(start), .stop(stop), .step(step), .state(state),
    .p_out(p_out), .n_out(n_out), .busy(busy), .done(done), .stuck(stuck),
    .cfg_err(cfg_err), .step_count(step_count)
  );

  pn_sequence_controller #(.WIDTH(2), .CNT_W(2)) sat (
    .clk(clk), .reset(reset), .cfg_we(s_cfg_we), .cfg_addr(s_cfg_addr), .cfg_next(s_cfg_next),
    .term_state(s_term_state), .start(s_start), .stop(s_stop), .step(s_step), .state(s_state),
    .p_out(s_p_out), .n_out(s_n_out), .busy(s_busy), .done(s_done), .stuck(s_stuck),
    .cfg_err(s_cfg_err), .step_count(s_step_count)
  );

  typedef struct packed {
    logic [1:0] st;
    logic       busy, done, stuck, err;
    logic [7:0] cnt;
  } obs_t;

  typedef struct packed {
    logic       start, stop, step, we, wok;
    logic [1:0] addr, nxt, term;
    obs_t       exp;
  } vec_t;

  vec_t       stim[$];
  obs_t       expq[$];
  logic [1:0] sq[$];
  logic [1:0] mtab [4];
  int         total = 0;
  int         bad = 0;

  function automatic obs_t sample();
    obs_t o;
    o = {state, busy, done, stuck, cfg_err, step_count};
    return o;
  endfunction

  function automatic vec_t v(input int start_i, stop_i, step_i, we_i, wok_i, addr_i, nxt_i,
                             term_i, st_i, busy_i, done_i, stuck_i, err_i, cnt_i);
    vec_t r;
    r.start     = 1'(start_i);
    r.stop      = 1'(stop_i);
    r.step      = 1'(step_i);
    r.we        = 1'(we_i);
    r.wok       = 1'(wok_i);
    r.addr      = 2'(addr_i);
    r.nxt       = 2'(nxt_i);
    r.term      = 2'(term_i);
    r.exp.st    = 2'(st_i);
    r.exp.busy  = 1'(busy_i);
    r.exp.done  = 1'(done_i);
    r.exp.stuck = 1'(stuck_i);
    r.exp.err   = 1'(err_i);
    r.exp.cnt   = 8'(cnt_i);
    return r;
  endfunction

  task automatic default_table();
    for (int i = 0; i < 4; i++) mtab[i] = 2'(i + 1);
  endtask

  // Apply one vector across a falling edge and queue its expectation.
  task automatic drive(input vec_t s);
    start = s.start; stop = s.stop; step = s.step;
    cfg_we = s.we; cfg_addr = s.addr; cfg_next = s.nxt; term_state = s.term;
    expq.push_back(s.exp);
    @(posedge clk); #1;
    if (s.wok) mtab[s.addr] = s.nxt;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b0; stop = 1'b0; step = 1'b0; cfg_we = 1'b0;
    cfg_addr = 2'd0; cfg_next = 2'd0; term_state = 2'd0;
    s_start = 1'b0; s_stop = 1'b0; s_step = 1'b0; s_cfg_we = 1'b0;
    s_cfg_addr = 2'd0; s_cfg_next = 2'd0; s_term_state = 2'd0;
    #2 reset = 1'b0;
    default_table();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; stop = 1'b0; step = 1'b0; cfg_we = 1'b0;
    cfg_addr = 2'd0; cfg_next = 2'd0; term_state = 2'd0;
    s_start = 1'b0; s_stop = 1'b0; s_step = 1'b0; s_cfg_we = 1'b0;
    s_cfg_addr = 2'd0; s_cfg_next = 2'd0; s_term_state = 2'd0;
    default_table();
    #3;
    total++;
    if (sample() !== '0 || p_out !== 2'b01 || n_out !== 2'b00) begin
      bad++;
      $display("FAIL reset: got obs=%h p=%b n=%b want obs=0 p=01 n=00", sample(), p_out, n_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_default_run();
    vec_t s; obs_t e; logic [1:0] ep, en;
    do_reset();
    stim.push_back(v(1,0,0,0,0, 0,0,3, 0,1,0,0,0,0));
    stim.push_back(v(0,0,0,0,0, 0,0,3, 1,1,0,0,0,1));
    stim.push_back(v(0,0,0,0,0, 0,0,3, 2,1,0,0,0,2));
    stim.push_back(v(0,0,0,0,0, 0,0,3, 3,0,1,0,0,3));
    stim.push_back(v(0,0,0,0,0, 0,0,3, 3,0,1,0,0,3));
    stim.push_back(v(0,1,0,0,0, 0,0,3, 3,0,0,0,0,3));
    while (stim.size() > 0) begin
      s = stim.pop_front(); drive(s); e = expq.pop_front();
      ep = mtab[e.st] & ~e.st; en = mtab[e.st] & e.st;
      total++;
      if (sample() !== e || p_out !== ep || n_out !== en) begin
        bad++;
        $display("FAIL default_run: got obs=%h p=%b n=%b want obs=%h p=%b n=%b",
                 sample(), p_out, n_out, e, ep, en);
      end
    end
  endtask

  task automatic test_custom_table();
    vec_t s; obs_t e; logic [1:0] ep, en;
    do_reset();
    stim.push_back(v(0,0,0,1,1, 0,3,2, 0,0,0,0,0,0));
    stim.push_back(v(0,0,0,1,1, 3,1,2, 0,0,0,0,0,0));
    stim.push_back(v(0,0,0,1,1, 1,2,2, 0,0,0,0,0,0));
    stim.push_back(v(0,0,0,1,1, 2,0,2, 0,0,0,0,0,0));
    stim.push_back(v(1,0,0,0,0, 0,0,2, 0,1,0,0,0,0));
    stim.push_back(v(0,0,0,1,0, 1,3,2, 3,1,0,0,1,1));
    stim.push_back(v(0,0,0,0,0, 0,0,2, 1,1,0,0,0,2));
    stim.push_back(v(0,0,0,0,0, 0,0,2, 2,0,1,0,0,3));
    stim.push_back(v(0,0,1,0,0, 0,0,2, 0,0,0,0,0,4));
    stim.push_back(v(0,0,1,0,0, 0,0,2, 3,0,0,0,0,5));
    stim.push_back(v(0,0,1,0,0, 0,0,2, 1,0,0,0,0,6));
    stim.push_back(v(0,0,1,0,0, 0,0,2, 2,0,0,0,0,7));
    while (stim.size() > 0) begin
      s = stim.pop_front(); drive(s); e = expq.pop_front();
      ep = mtab[e.st] & ~e.st; en = mtab[e.st] & e.st;
      total++;
      if (sample() !== e || p_out !== ep || n_out !== en) begin
        bad++;
        $display("FAIL custom_table: got obs=%h p=%b n=%b want obs=%h p=%b n=%b",
                 sample(), p_out, n_out, e, ep, en);
      end
    end
  endtask

  task automatic test_stuck();
    vec_t s; obs_t e; logic [1:0] ep, en;
    do_reset();
    stim.push_back(v(0,0,0,1,1, 1,1,3, 0,0,0,0,0,0));
    stim.push_back(v(1,0,0,0,0, 0,0,3, 0,1,0,0,0,0));
    stim.push_back(v(0,0,0,0,0, 0,0,3, 1,0,0,1,0,1));
    stim.push_back(v(0,0,0,0,0, 0,0,3, 1,0,0,0,0,1));
    while (stim.size() > 0) begin
      s = stim.pop_front(); drive(s); e = expq.pop_front();
      ep = mtab[e.st] & ~e.st; en = mtab[e.st] & e.st;
      total++;
      if (sample() !== e || p_out !== ep || n_out !== en) begin
        bad++;
        $display("FAIL stuck: got obs=%h p=%b n=%b want obs=%h p=%b n=%b",
                 sample(), p_out, n_out, e, ep, en);
      end
    end
  endtask

  task automatic test_step();
    vec_t s; obs_t e; logic [1:0] ep, en;
    do_reset();
    stim.push_back(v(0,0,1,0,0, 0,0,0, 1,0,0,0,0,1));
    stim.push_back(v(0,0,1,0,0, 0,0,0, 2,0,0,0,0,2));
    stim.push_back(v(0,0,1,0,0, 0,0,0, 3,0,0,0,0,3));
    stim.push_back(v(1,0,1,0,0, 0,0,3, 3,1,0,0,0,0));
    stim.push_back(v(0,0,0,0,0, 0,0,3, 0,1,0,0,0,1));
    stim.push_back(v(0,1,0,0,0, 0,0,3, 0,0,0,0,0,1));
    while (stim.size() > 0) begin
      s = stim.pop_front(); drive(s); e = expq.pop_front();
      ep = mtab[e.st] & ~e.st; en = mtab[e.st] & e.st;
      total++;
      if (sample() !== e || p_out !== ep || n_out !== en) begin
        bad++;
        $display("FAIL step: got obs=%h p=%b n=%b want obs=%h p=%b n=%b",
                 sample(), p_out, n_out, e, ep, en);
      end
    end
  endtask

  task automatic test_stop_write();
    vec_t s; obs_t e; logic [1:0] ep, en;
    do_reset();
    stim.push_back(v(1,0,0,0,0, 0,0,0, 0,1,0,0,0,0));
    stim.push_back(v(0,0,0,0,0, 0,0,0, 1,1,0,0,0,1));
    stim.push_back(v(0,1,0,1,0, 1,0,0, 1,0,0,0,1,1));
    stim.push_back(v(0,0,0,0,0, 0,0,0, 1,0,0,0,0,1));
    stim.push_back(v(0,0,1,0,0, 0,0,0, 2,0,0,0,0,2));
    while (stim.size() > 0) begin
      s = stim.pop_front(); drive(s); e = expq.pop_front();
      ep = mtab[e.st] & ~e.st; en = mtab[e.st] & e.st;
      total++;
      if (sample() !== e || p_out !== ep || n_out !== en) begin
        bad++;
        $display("FAIL stop_write: got obs=%h p=%b n=%b want obs=%h p=%b n=%b",
                 sample(), p_out, n_out, e, ep, en);
      end
    end
  endtask

  task automatic test_async_reset();
    vec_t s; obs_t e; logic [1:0] ep, en;
    do_reset();
    stim.push_back(v(0,0,0,1,1, 1,3,0, 0,0,0,0,0,0));
    stim.push_back(v(1,0,0,0,0, 0,0,0, 0,1,0,0,0,0));
    stim.push_back(v(0,0,0,0,0, 0,0,0, 1,1,0,0,0,1));
    stim.push_back(v(0,0,0,0,0, 0,0,0, 3,1,0,0,0,2));
    while (stim.size() > 0) begin
      s = stim.pop_front(); drive(s); e = expq.pop_front();
      ep = mtab[e.st] & ~e.st; en = mtab[e.st] & e.st;
      total++;
      if (sample() !== e || p_out !== ep || n_out !== en) begin
        bad++;
        $display("FAIL async_pre: got obs=%h p=%b n=%b want obs=%h p=%b n=%b",
                 sample(), p_out, n_out, e, ep, en);
      end
    end
    // Reset lands between edges while the sequencer is running.
    start = 1'b0; stop = 1'b0; step = 1'b0; cfg_we = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (sample() !== '0 || p_out !== 2'b01 || n_out !== 2'b00) begin
      bad++;
      $display("FAIL async_reset: got obs=%h p=%b n=%b want obs=0 p=01 n=00", sample(), p_out, n_out);
    end
    reset = 1'b0;
    default_table();
    stim.push_back(v(0,0,1,0,0, 0,0,0, 1,0,0,0,0,1));
    stim.push_back(v(0,0,1,0,0, 0,0,0, 2,0,0,0,0,2));
    while (stim.size() > 0) begin
      s = stim.pop_front(); drive(s); e = expq.pop_front();
      ep = mtab[e.st] & ~e.st; en = mtab[e.st] & e.st;
      total++;
      if (sample() !== e || p_out !== ep || n_out !== en) begin
        bad++;
        $display("FAIL async_post: got obs=%h p=%b n=%b want obs=%h p=%b n=%b",
                 sample(), p_out, n_out, e, ep, en);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] ec;
    do_reset();
    s_cfg_we = 1'b1; s_cfg_addr = 2'd1; s_cfg_next = 2'd0; s_term_state = 2'd3;
    @(posedge clk); #1;
    s_cfg_we = 1'b0; s_start = 1'b1;
    sq.push_back(2'd0);
    @(posedge clk); #1;
    s_start = 1'b0;
    ec = sq.pop_front();
    total++;
    if (s_step_count !== ec || s_busy !== 1'b1) begin
      bad++;
      $display("FAIL sat_start: got cnt=%0d busy=%b want cnt=%0d busy=1", s_step_count, s_busy, ec);
    end
    for (int i = 1; i <= 6; i++) begin
      sq.push_back((i >= 3) ? 2'd3 : 2'(i));
      @(posedge clk); #1;
      ec = sq.pop_front();
      total++;
      if (s_step_count !== ec || s_busy !== 1'b1 || s_stuck !== 1'b0) begin
        bad++;
        $display("FAIL sat_count: got cnt=%0d busy=%b stuck=%b want cnt=%0d busy=1 stuck=0",
                 s_step_count, s_busy, s_stuck, ec);
      end
    end
    s_stop = 1'b1;
    @(posedge clk); #1;
    s_stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_custom_table();
    test_stuck();
    test_step();
    test_stop_write();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pn_sequence_controller.md
Name: pn_sequence_controller

Overview:
- Programmable sequencer for a bank of WIDTH PN flip-flops. A PN flip-flop's next state is (N & Q) | (P & ~Q).
- Holds a next-state table, one entry per state, that software can rewrite. Derives the P/N excitation for every bit from the table and steps the bank under start/stop/step commands.
- Generalises the fixed two-bit PN state machines in the design to a run-time configurable sequence with terminal-state detection.

Parameters:
- WIDTH, 2, number of state bits. The table has 2**WIDTH entries of WIDTH bits.
- CNT_W, 8, width of the saturating step counter.

Ports:
- clk  in  1  clock. All state updates occur on the falling edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  WIDTH  table entry (current state) to write.
- cfg_next  in  WIDTH  next-state value to store.
- term_state  in  WIDTH  terminal state. Sampled every edge.
- start  in  1  begin free-running sequencing.
- stop  in  1  abort free-running sequencing.
- step  in  1  advance exactly one state while idle.
- state  out  WIDTH  current bank contents (Q of each PN flip-flop).
- p_out  out  WIDTH  P excitation: table[state] & ~state.
- n_out  out  WIDTH  N excitation: table[state] & state.
- busy  out  1  high in RUN.
- done  out  1  high while in HALT.
- stuck  out  1  one-cycle pulse when RUN hits a non-terminal self-loop.
- cfg_err  out  1  one-cycle pulse when a write is attempted during RUN.
- step_count  out  CNT_W  number of advances since last start/reset. Saturates at all-ones.

Behaviour:
- Reset (asynchronous, any time, including mid-RUN):
  - state=0, FSM=IDLE, busy=0, done=0, stuck=0, cfg_err=0, step_count=0.
  - table[i] = (i+1) mod 2**WIDTH, i.e. a binary counter.
- Bank update:
  - Each bit i is a PN flip-flop fed by p_out[i]/n_out[i].
  - The bank's next state equals table[state] whenever an advance is enabled. Otherwise the bank holds (P=0, N=1 on set bits).
  - p_out/n_out are combinational from state and the table.
- FSM states: IDLE, RUN, HALT.
- IDLE:
  - start → RUN and clear step_count (no advance on this edge).
  - step (without start) → one advance, step_count+1, stay IDLE.
  - start and step together: start wins.
- RUN (busy=1):
  - Each falling edge advances once and increments step_count.
  - stop → IDLE with no advance on that edge. stop beats all other conditions.
  - If the post-advance state equals term_state → HALT.
  - Else if table[new state] == new state → IDLE and pulse stuck for one cycle.
  - step is ignored.
- HALT (done=1, bank holds):
  - start → RUN, done clears, step_count clears.
  - step → one advance, go to IDLE.
  - stop → IDLE.
- Table writes:
  - Accepted on any edge with cfg_we=1 in IDLE or HALT.
  - During RUN the write is dropped and cfg_err pulses for one cycle.
  - A write to table[state] on the same edge as an advance: the advance uses the old entry.
- Boundary cases:
  - start in IDLE when state already equals term_state: first advance proceeds. Termination is checked only after an advance.
  - step_count holds at 2**CNT_W-1.
  - With WIDTH=2 the default table wraps 3→0.

Test Plan:
- Reset pulse, then start, term_state=3, default table → state 0,1,2,3 on successive falling edges; done=1 after 3 advances; step_count=3; p_out/n_out consistent at every edge.
- Write table {0→3, 3→1, 1→2, 2→0}, term_state=2, start → sequence 0,3,1,2, then HALT. Write during RUN pulses cfg_err and the table is unchanged.
- Write table[1]=1, term_state=3, start from 0 → state 0→1, stuck pulse, FSM=IDLE, state holds 1.
- In IDLE, pulse step three times → state 0→1→2→3, busy stays 0, step_count=3. Assert start and step together → RUN with no advance on that edge.
- RUN with stop and a write asserted on the same edge → IDLE, no advance, cfg_err=1. Then assert reset mid-RUN between clock edges → all outputs zero immediately and the table returns to the default.
- Drive step_count to saturation with CNT_W=2 and a non-terminating loop → count holds at 3.
